vram_arbiter: RTL and testbench

Single-port access arbiter and clear sequencer for the 8x8 LED frame RAM. Three requesters share the RAM port: the scan reader (refresh reads), the light-pen writer (cell updates), and an internal clear engine that sweeps all 64 cells to a fixed value. The block sits between the scan/pen logic and the frame RAM. It guarantees that scan reads never stall, that pen writes are never lost, and that a frame clear is atomic with respect to pen writes.

---
 rtl/vram_arbiter_pkg.sv | 20 ++
 rtl/vram_pen_fifo.sv | 55 +++++
 rtl/vram_arbiter.sv | 166 ++++++++++++++++
 tb/tb_vram_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_arbiter_pkg.sv
// Shared grant codes, clear-FSM state encoding and frame geometry for the
// LED frame-RAM arbiter.
package vram_arbiter_pkg;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_SCAN = 2'd1,
    GNT_PEN  = 2'd2,
    GNT_CLR  = 2'd3
  } gnt_e;

  typedef enum logic [1:0] {
    CLR_IDLE = 2'd0,
    CLR_RUN  = 2'd1,
    CLR_DONE = 2'd2
  } clr_state_e;

  localparam int VRAM_CELLS = 64;

endpackage

// File: rtl/vram_pen_fifo.sv
// Two-entry synchronous FIFO buffering pen writes ({row, col, data}) while
// the RAM port is busy with scan reads or a frame clear.
module vram_pen_fifo #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_pop,
  output logic [W-1:0] out_data
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         push, pop;

  always_comb begin
    in_ready  = (count_q != 2'd2);
    out_valid = (count_q != 2'd0);
    out_data  = mem_q[rd_ptr_q];
    push      = in_valid && in_ready;
    pop       = out_pop && out_valid;
    wr_ptr_d  = wr_ptr_q ^ push;
    rd_ptr_d  = rd_ptr_q ^ pop;
    count_d   = count_q + {1'b0, push} - {1'b0, pop};
    mem_d     = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage carries no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/vram_arbiter.sv
// Frame-RAM port arbiter (scan > clear > pen) with atomic 64-cell clear engine.
// Define VRAM_ARB_PEN_FIFO_EN to buffer pen writes in a 2-entry FIFO.
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int                ROWS     = 8,
  parameter int                COLS     = 8,
  parameter int                DATA_W   = 4,
  parameter logic [DATA_W-1:0] CLR_DATA = '0,
  localparam int               RW       = $clog2(ROWS),
  localparam int               CW       = $clog2(COLS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scan_req,
  input  logic [RW-1:0]     scan_row,
  input  logic [CW-1:0]     scan_col,
  output logic              scan_rvalid,
  output logic [DATA_W-1:0] scan_rdata,
  input  logic              pen_valid,
  output logic              pen_ready,
  input  logic [RW-1:0]     pen_row,
  input  logic [CW-1:0]     pen_col,
  input  logic [DATA_W-1:0] pen_data,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              ram_we,
  output logic              ram_re,
  output logic [RW-1:0]     ram_row,
  output logic [CW-1:0]     ram_col,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [1:0]        gnt
);

  localparam int               CNT_W    = RW + CW;
  localparam int               PW       = RW + CW + DATA_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROWS * COLS - 1);

  clr_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              scan_rvalid_q, scan_rvalid_d;
  logic              clr_gnt;
  logic              pen_issue;
  logic [RW-1:0]     pen_w_row;
  logic [CW-1:0]     pen_w_col;
  logic [DATA_W-1:0] pen_w_data;
  gnt_e              gnt_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= CLR_IDLE;
      cnt_q         <= '0;
      scan_rvalid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      scan_rvalid_q <= scan_rvalid_d;
    end
  end

  // Counter only moves on cycles the clear actually owns the port.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    scan_rvalid_d = scan_req;
    case (state_q)
      CLR_IDLE: begin
        if (clr_start) begin
          state_d = CLR_RUN;
          cnt_d   = '0;
        end
      end
      CLR_RUN: begin
        if (clr_gnt) begin
          if (cnt_q == CNT_LAST) begin
            state_d = CLR_DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      CLR_DONE: state_d = CLR_IDLE;
      default:  state_d = CLR_IDLE;
    endcase
  end

  always_comb begin
    clr_busy = (state_q != CLR_IDLE);
    clr_done = (state_q == CLR_DONE);
    clr_gnt  = (state_q == CLR_RUN) && !scan_req;
  end

`ifdef VRAM_ARB_PEN_FIFO_EN
  logic          fifo_ready;
  logic          fifo_valid;
  logic [PW-1:0] fifo_head;

  vram_pen_fifo #(
    .W(PW)
  ) u_pen_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (pen_valid),
    .in_ready  (fifo_ready),
    .in_data   ({pen_row, pen_col, pen_data}),
    .out_valid (fifo_valid),
    .out_pop   (pen_issue),
    .out_data  (fifo_head)
  );

  assign pen_ready = !rst && fifo_ready;
  assign pen_issue = fifo_valid && !scan_req && !clr_busy;
  assign {pen_w_row, pen_w_col, pen_w_data} = fifo_head;
`else
  // Without buffering a pen write is only accepted when it can go out now.
  assign pen_ready = !rst && !scan_req && !clr_busy && !clr_start;
  assign pen_issue = pen_valid && pen_ready;
  assign {pen_w_row, pen_w_col, pen_w_data} = {pen_row, pen_col, pen_data};
`endif

  always_comb begin
    gnt_sel = GNT_NONE;
    if (scan_req) begin
      gnt_sel = GNT_SCAN;
    end else if (clr_gnt) begin
      gnt_sel = GNT_CLR;
    end else if (pen_issue) begin
      gnt_sel = GNT_PEN;
    end
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_row   = '0;
    ram_col   = '0;
    ram_wdata = '0;
    case (gnt_sel)
      GNT_SCAN: begin
        ram_re  = 1'b1;
        ram_row = scan_row;
        ram_col = scan_col;
      end
      GNT_CLR: begin
        ram_we    = 1'b1;
        ram_row   = cnt_q[CNT_W-1:CW];
        ram_col   = cnt_q[CW-1:0];
        ram_wdata = CLR_DATA;
      end
      GNT_PEN: begin
        ram_we    = 1'b1;
        ram_row   = pen_w_row;
        ram_col   = pen_w_col;
        ram_wdata = pen_w_data;
      end
      default: ;
    endcase
  end

  assign gnt         = gnt_sel;
  assign scan_rvalid = scan_rvalid_q;
  assign scan_rdata  = ram_rdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: vector table for single-cycle grants plus
// sequences for scan priority, clears under traffic, pen-vs-clear and reset.
module tb_vram_arbiter;
  import vram_arbiter_pkg::*;

`ifdef VRAM_ARB_PEN_FIFO_EN
  localparam bit FIFO_BUILD = 1'b1;
`else
  localparam bit FIFO_BUILD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, scan_req, pen_valid, clr_start;
  logic [2:0] scan_row, scan_col, pen_row, pen_col, ram_row, ram_col;
  logic [3:0] pen_data, scan_rdata, ram_wdata;
  logic [3:0] ram_rdata;
  logic       scan_rvalid, pen_ready, clr_busy, clr_done, ram_we, ram_re;
  logic [1:0] gnt;

  logic       bd_we = 1'b0;
  logic [2:0] bd_row = 3'd0, bd_col = 3'd0;
  logic [3:0] bd_data = 4'd0;
  logic [3:0] mem [8][8];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    logic [2:0] row;
    logic [2:0] col;
    logic [3:0] data;
    int         cyc;
  } wr_t;
  wr_t clr_log[$];
  wr_t pen_log[$];
  int  done_cnt = 0;
  int  done_cyc = -1;

  typedef struct {
    logic       scan;
    logic [2:0] sr, sc;
    logic       pv;
    logic [2:0] pr, pc;
    logic [3:0] pd;
    logic [1:0] g;
    logic       we, re;
    logic [2:0] row, col;
    logic [3:0] wd;
    logic       rdy;
  } vec_t;
  vec_t vt[$];

  always #5 clk = ~clk;

  vram_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .scan_req    (scan_req),
    .scan_row    (scan_row),
    .scan_col    (scan_col),
    .scan_rvalid (scan_rvalid),
    .scan_rdata  (scan_rdata),
    .pen_valid   (pen_valid),
    .pen_ready   (pen_ready),
    .pen_row     (pen_row),
    .pen_col     (pen_col),
    .pen_data    (pen_data),
    .clr_start   (clr_start),
    .clr_busy    (clr_busy),
    .clr_done    (clr_done),
    .ram_we      (ram_we),
    .ram_re      (ram_re),
    .ram_row     (ram_row),
    .ram_col     (ram_col),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
    .gnt         (gnt)
  );

  // Frame RAM with 1-cycle registered read, plus a backdoor preload port.
  always @(posedge clk) begin
    if (bd_we) mem[bd_row][bd_col] <= bd_data;
    else if (ram_we) mem[ram_row][ram_col] <= ram_wdata;
    if (ram_re) ram_rdata <= mem[ram_row][ram_col];
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ram_we && gnt == GNT_CLR) clr_log.push_back('{ram_row, ram_col, ram_wdata, cyc});
    if (ram_we && gnt == GNT_PEN) pen_log.push_back('{ram_row, ram_col, ram_wdata, cyc});
    if (clr_done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    if (ram_we || ram_re) check("we_re_exclusive", {31'd0, ram_we & ram_re}, 32'd0);
  endtask

  task automatic idle();
    scan_req = 1'b0; scan_row = 3'd0; scan_col = 3'd0;
    pen_valid = 1'b0; pen_row = 3'd0; pen_col = 3'd0; pen_data = 4'd0;
    clr_start = 1'b0;
  endtask

  task automatic read_cell(input int r, input int c, input logic [3:0] exp, input string name);
    scan_req = 1'b1;
    scan_row = 3'(r);
    scan_col = 3'(c);
    tick();
    scan_req = 1'b0;
    mid();
    check($sformatf("%s(%0d,%0d)", name, r, c), {27'd0, scan_rvalid, scan_rdata}, {27'd0, 1'b1, exp});
    tick();
  endtask

  task automatic read_all(input int sr, input int sc, input logic [3:0] sv, input string name);
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        read_cell(r, c, (r == sr && c == sc) ? sv : 4'h0, name);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  s, s2, k, d0, n0, n1, p0, acc, acc_cyc, errs;
    wr_t w;
    vec_t v;

    vt.push_back('{1'b0, 3'd0, 3'd0, 1'b0, 3'd6, 3'd6, 4'h5, GNT_NONE, 1'b0, 1'b0, 3'd0, 3'd0, 4'h0, 1'b1});
    vt.push_back('{1'b1, 3'd7, 3'd0, 1'b0, 3'd0, 3'd0, 4'h0, GNT_SCAN, 1'b0, 1'b1, 3'd7, 3'd0, 4'h0, FIFO_BUILD});
    vt.push_back('{1'b1, 3'd0, 3'd7, 1'b0, 3'd2, 3'd2, 4'h2, GNT_SCAN, 1'b0, 1'b1, 3'd0, 3'd7, 4'h0, FIFO_BUILD});
`ifndef VRAM_ARB_PEN_FIFO_EN
    vt.push_back('{1'b0, 3'd0, 3'd0, 1'b1, 3'd4, 3'd4, 4'h3, GNT_PEN,  1'b1, 1'b0, 3'd4, 3'd4, 4'h3, 1'b1});
    vt.push_back('{1'b0, 3'd5, 3'd5, 1'b1, 3'd7, 3'd7, 4'h9, GNT_PEN,  1'b1, 1'b0, 3'd7, 3'd7, 4'h9, 1'b1});
    vt.push_back('{1'b1, 3'd3, 3'd4, 1'b1, 3'd1, 3'd2, 4'h6, GNT_SCAN, 1'b0, 1'b1, 3'd3, 3'd4, 4'h0, 1'b0});
`endif

    // Reset state
    idle();
    rst = 1'b1;
    tick();
    tick();
    mid();
    check("rst_pen_ready_low", {31'd0, pen_ready}, 32'd0);
    tick();
    rst = 1'b0;
    mid();
    check("rst_pen_ready_rise", {31'd0, pen_ready}, 32'd1);
    check("rst_port_idle", {18'd0, gnt, ram_we, ram_re, ram_row, ram_col, ram_wdata}, 32'd0);
    check("rst_flags", {29'd0, scan_rvalid, clr_busy, clr_done}, 32'd0);
    tick();

    // Scan read of a preloaded cell
    bd_we = 1'b1; bd_row = 3'd2; bd_col = 3'd5; bd_data = 4'hA;
    tick();
    bd_we = 1'b0;
    scan_req = 1'b1; scan_row = 3'd2; scan_col = 3'd5;
    mid();
    check("scan_issue", {22'd0, gnt, ram_re, ram_we, ram_row, ram_col}, {22'd0, GNT_SCAN, 1'b1, 1'b0, 3'd2, 3'd5});
    tick();
    scan_req = 1'b0;
    mid();
    check("scan_rdata", {27'd0, scan_rvalid, scan_rdata}, {27'd0, 1'b1, 4'hA});
    tick();
    mid();
    check("scan_rvalid_drop", {31'd0, scan_rvalid}, 32'd0);
    tick();

    // Single-cycle grant vectors
    for (int i = 0; i < vt.size(); i++) begin
      v = vt[i];
      scan_req = v.scan; scan_row = v.sr; scan_col = v.sc;
      pen_valid = v.pv; pen_row = v.pr; pen_col = v.pc; pen_data = v.pd;
      mid();
      check($sformatf("vec%0d", i), {17'd0, gnt, ram_we, ram_re, ram_row, ram_col, ram_wdata, pen_ready},
            {17'd0, v.g, v.we, v.re, v.row, v.col, v.wd, v.rdy});
      tick();
    end
    idle();
    tick();

    // Scan held for 3 cycles starves the pen write, which goes out right after
    acc = 0;
    pen_row = 3'd3; pen_col = 3'd3; pen_data = 4'hB;
    for (int i = 0; i < 3; i++) begin
      scan_req = 1'b1;
      pen_valid = (acc == 0);
      mid();
      check("sb_no_we", {31'd0, ram_we}, 32'd0);
`ifndef VRAM_ARB_PEN_FIFO_EN
      check("sb_rdy_low", {31'd0, pen_ready}, 32'd0);
`endif
      if (pen_valid && pen_ready) acc = 1;
      tick();
    end
    scan_req = 1'b0;
    pen_valid = (acc == 0);
    mid();
    check("sb_pen_issue", {17'd0, gnt, ram_we, ram_row, ram_col, ram_wdata}, {17'd0, GNT_PEN, 1'b1, 3'd3, 3'd3, 4'hB});
    tick();
    idle();
    read_cell(3, 3, 4'hB, "sb_readback");

    // Clear with a scan every 4th cycle plus an ignored restart at k=22
    s = cyc; d0 = done_cnt; n0 = clr_log.size();
    clr_start = 1'b1;
    mid();
    check("clr_start_cycle", {29'd0, gnt, clr_busy}, 32'd0);
    tick();
    clr_start = 1'b0;
    k = 1;
    while (done_cnt == d0 && k < 200) begin
      scan_req = (k % 4 == 0);
      scan_row = 3'(k % 8);
      clr_start = (k == 22);
      mid();
      if (scan_req) check("clr_scan_gnt", {30'd0, gnt}, {30'd0, GNT_SCAN});
      if (k == 10) check("clr_busy", {31'd0, clr_busy}, 32'd1);
      tick();
      k++;
    end
    idle();
    check("clr_done_seen", done_cnt - d0, 1);
    check("clr_len", done_cyc - s, 86);
    check("clr_write_count", clr_log.size() - n0, VRAM_CELLS);
    errs = 0;
    for (int i = 0; i < VRAM_CELLS && n0 + i < clr_log.size(); i++) begin
      w = clr_log[n0 + i];
      if ({w.row, w.col} != 6'(i) || w.data != 4'h0) errs++;
    end
    check("clr_order_errs", errs, 0);
    if (clr_log.size() > 0) check("clr_done_after_last", done_cyc - clr_log[clr_log.size() - 1].cyc, 1);
    tick();
    read_all(-1, -1, 4'h0, "clr_readback");

    // Pen write offered 10 cycles into a clear survives it
    s = cyc; d0 = done_cnt; p0 = pen_log.size(); acc_cyc = -1;
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    pen_row = 3'd1; pen_col = 3'd1; pen_data = 4'hF;
    k = 1;
    while (pen_log.size() == p0 && k < 300) begin
      pen_valid = (k >= 10) && (acc_cyc < 0);
      mid();
      if (pen_valid && pen_ready) acc_cyc = cyc;
      tick();
      k++;
    end
    idle();
    check("pdc_done_seen", done_cnt - d0, 1);
    check("pdc_clr_len", done_cyc - s, 65);
    check("pdc_pen_writes", pen_log.size() - p0, 1);
    if (pen_log.size() > p0) begin
      check("pdc_pen_cyc", pen_log[p0].cyc, done_cyc + 1);
      check("pdc_pen_data", {22'd0, pen_log[p0].row, pen_log[p0].col, pen_log[p0].data}, {22'd0, 3'd1, 3'd1, 4'hF});
    end
`ifdef VRAM_ARB_PEN_FIFO_EN
    check("pdc_accept_cyc", acc_cyc, s + 10);
`else
    check("pdc_accept_cyc", acc_cyc, done_cyc + 1);
`endif
    tick();
    read_all(1, 1, 4'hF, "pdc_readback");

`ifdef VRAM_ARB_PEN_FIFO_EN
    // Three back-to-back pen writes during a clear: only two fit
    s = cyc; d0 = done_cnt; p0 = pen_log.size(); acc = 0; errs = 0;
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    k = 1;
    while (pen_log.size() - p0 < 3 && k < 300) begin
      pen_valid = (k >= 5) && (acc < 3);
      pen_row = 3'd5; pen_col = 3'(acc + 1); pen_data = 4'(acc + 1);
      mid();
      if (k == 7) check("full_rdy_low", {31'd0, pen_ready}, 32'd0);
      if (pen_valid && pen_ready) begin
        acc++;
        if (clr_busy) errs++;
      end
      tick();
      k++;
    end
    idle();
    check("full_accepts_in_clear", errs, 2);
    check("full_writes", pen_log.size() - p0, 3);
    for (int i = 0; i < 3 && p0 + i < pen_log.size(); i++) begin
      w = pen_log[p0 + i];
      check($sformatf("full_order%0d", i), {22'd0, w.row, w.col, w.data}, {22'd0, 3'd5, 3'(i + 1), 4'(i + 1)});
    end
    if (pen_log.size() > p0) check("full_first_cyc", pen_log[p0].cyc, done_cyc + 1);
    tick();
`endif

    // Reset at clear count 30 aborts it; then a fresh clear completes
    s = cyc; d0 = done_cnt; n0 = clr_log.size(); p0 = pen_log.size();
    clr_start = 1'b1;
    mid();
`ifndef VRAM_ARB_PEN_FIFO_EN
    check("start_blocks_pen", {31'd0, pen_ready}, 32'd0);
`endif
    tick();
    clr_start = 1'b0;
    pen_row = 3'd6; pen_col = 3'd6; pen_data = 4'h7;
    k = 1;
    while (clr_log.size() - n0 < 30 && k < 100) begin
      pen_valid = (k == 5);
      mid();
      tick();
      k++;
    end
    idle();
    check("rmc_count_at_rst", clr_log.size() - n0, 30);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mid();
    check("rmc_flags", {29'd0, clr_busy, clr_done, scan_rvalid}, 32'd0);
    check("rmc_port", {18'd0, gnt, ram_we, ram_re, ram_row, ram_col, ram_wdata}, 32'd0);
    check("rmc_pen_ready", {31'd0, pen_ready}, 32'd1);
    tick();
    for (int i = 0; i < 80; i++) tick();
    check("rmc_no_done", done_cnt - d0, 0);
    check("rmc_fifo_empty", pen_log.size() - p0, 0);

    s2 = cyc; n1 = clr_log.size();
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    k = 1;
    while (done_cnt == d0 && k < 200) begin
      tick();
      k++;
    end
    check("rmc_new_done", done_cnt - d0, 1);
    check("rmc_new_len", done_cyc - s2, 65);
    check("rmc_new_writes", clr_log.size() - n1, VRAM_CELLS);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
